// File: rtl/snake_pkg.sv
// Shared pixel-stream types and the CRC-16-CCITT helper used by the frame
// checker and by golden models that need the same signature.
package snake_pkg;
  localparam int RGB_B = 12;
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  typedef enum logic {IDLE, CAPTURE} chk_state_e;

  // One clock of the signature: the whole 12-bit pixel, MSB (r[3]) first.
  function automatic logic [15:0] crc16_step12(input logic [15:0] crc,
                                               input logic [RGB_B-1:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = RGB_B-1; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction
endpackage

// File: rtl/vga_if.sv
// VGA timing bundle as produced by the timing generator / renderer.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hblnk;
  logic        vblnk;
  logic        hsync;
  logic        vsync;

  modport out (output hcount, vcount, hblnk, vblnk, hsync, vsync);
  modport in  (input  hcount, vcount, hblnk, vblnk, hsync, vsync);
endinterface

// File: rtl/crc16_12b.sv
// Registered CRC-16 accumulator: seed has priority over enable. crc_nxt_o
// exposes the value including the current pixel so a frame close can
// publish a pixel that arrives on the closing cycle.
module crc16_12b
  import snake_pkg::*;
#(
  parameter logic [15:0] INIT = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_i,
  input  logic             en_i,
  input  logic [RGB_B-1:0] data_i,
  output logic [15:0]      crc_o,
  output logic [15:0]      crc_nxt_o
);
  logic [15:0] crc_q, crc_d;

  assign crc_nxt_o = en_i ? crc16_step12(crc_q, data_i) : crc_q;
  assign crc_d     = seed_i ? INIT : crc_nxt_o;
  assign crc_o     = crc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= '0;
    else        crc_q <= crc_d;
  end
endmodule

// File: rtl/vga_frame_checker.sv
// Passive frame checker: CRC-16 signature of each complete frame's active
// area plus line-length and line-count geometry checks.
module vga_frame_checker
  import snake_pkg::*;
#(
  parameter int          H_ACTIVE = 1024,
  parameter int          V_ACTIVE = 768,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  vga_if.in                vga_in,
  input  logic [RGB_B-1:0] rgb,
  input  logic             clr,
  output logic [15:0]      crc,
  output logic             crc_valid,
  output logic [15:0]      frame_cnt,
  output logic [10:0]      lines_seen,
  output logic             line_err,
  output logic             frame_err
);
  logic             hblnk_q, vblnk_q, vsync_q, hblnk_qq, vsync_qq;
  logic [RGB_B-1:0] rgb_q;
  logic [10:0]      px_q, px_d, line_acc_q, line_acc_d, lines_tot;
  logic [15:0]      crc_q, crc_d, frame_cnt_q, frame_cnt_d, crc_acc, crc_nxt;
  logic [10:0]      lines_seen_q, lines_seen_d;
  logic             crc_valid_q, line_err_q, line_err_d, frame_err_q, frame_err_d;
  logic             active, vs_rise, hb_rise, line_evt, line_bad, arm, close;
  chk_state_e       state_q, state_d;

  // Position and hsync are not needed for the checks.
  logic unused_vga;
  assign unused_vga = ^{vga_in.hcount, vga_in.vcount, vga_in.hsync, crc_acc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {hblnk_q, vblnk_q, vsync_q, hblnk_qq, vsync_qq} <= '0;
      rgb_q <= '0;
    end else begin
      hblnk_q  <= vga_in.hblnk;
      vblnk_q  <= vga_in.vblnk;
      vsync_q  <= vga_in.vsync;
      rgb_q    <= rgb;
      hblnk_qq <= hblnk_q;
      vsync_qq <= vsync_q;
    end
  end

  assign active    = !hblnk_q && !vblnk_q;
  assign vs_rise   = vsync_q && !vsync_qq;
  assign hb_rise   = hblnk_q && !hblnk_qq;
  assign line_evt  = hb_rise && (px_q != '0);
  assign line_bad  = line_evt && (px_q != 11'(H_ACTIVE));
  assign lines_tot = line_acc_q + {10'd0, line_evt};

  always_comb begin
    state_d = state_q;
    arm     = 1'b0;
    close   = 1'b0;
    case (state_q)
      IDLE:    if (vs_rise) begin arm = 1'b1; state_d = CAPTURE; end
      CAPTURE: close = vs_rise;
      default: state_d = IDLE;
    endcase
  end

  crc16_12b #(.INIT(CRC_INIT)) u_crc (
    .clk       (clk),
    .rst_n     (rst),
    .seed_i    (vs_rise),
    .en_i      (active),
    .data_i    (rgb_q),
    .crc_o     (crc_acc),
    .crc_nxt_o (crc_nxt)
  );

  always_comb begin
    px_d = px_q;
    if (arm || hb_rise) px_d = '0;
    else if (active)    px_d = px_q + 11'd1;

    line_acc_d = line_acc_q;
    if (arm || close)   line_acc_d = '0;
    else if (line_evt)  line_acc_d = lines_tot;

    crc_d        = close ? crc_nxt   : crc_q;
    lines_seen_d = close ? lines_tot : lines_seen_q;

    // clr wins over a coinciding close for the counter and sticky flags.
    frame_cnt_d = frame_cnt_q;
    line_err_d  = line_err_q;
    frame_err_d = frame_err_q;
    if (clr) begin
      frame_cnt_d = '0;
      line_err_d  = 1'b0;
      frame_err_d = 1'b0;
    end else begin
      if (close) frame_cnt_d = frame_cnt_q + 16'd1;
      if (state_q == CAPTURE && line_bad) line_err_d = 1'b1;
      if (close && lines_tot != 11'(V_ACTIVE)) frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      px_q         <= '0;
      line_acc_q   <= '0;
      crc_q        <= '0;
      crc_valid_q  <= 1'b0;
      frame_cnt_q  <= '0;
      lines_seen_q <= '0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      px_q         <= px_d;
      line_acc_q   <= line_acc_d;
      crc_q        <= crc_d;
      crc_valid_q  <= close;
      frame_cnt_q  <= frame_cnt_d;
      lines_seen_q <= lines_seen_d;
      line_err_q   <= line_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign crc        = crc_q;
  assign crc_valid  = crc_valid_q;
  assign frame_cnt  = frame_cnt_q;
  assign lines_seen = lines_seen_q;
  assign line_err   = line_err_q;
  assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_vga_frame_checker.sv
// Directed bench on a shrunken 8x4 active window (12x6 total) so each frame
// is 72 cycles; golden CRCs come from an independent bitwise model.
module tb_vga_frame_checker;
  import snake_pkg::*;

  logic             clk, rst_n, clr;
  logic [RGB_B-1:0] rgb;
  logic [15:0]      crc, frame_cnt;
  logic             crc_valid, line_err, frame_err;
  logic [10:0]      lines_seen;

  vga_if vga();

  vga_frame_checker #(.H_ACTIVE(8), .V_ACTIVE(4), .CRC_INIT(16'hFFFF)) dut (
    .clk(clk), .rst(rst_n), .vga_in(vga), .rgb(rgb), .clr(clr),
    .crc(crc), .crc_valid(crc_valid), .frame_cnt(frame_cnt),
    .lines_seen(lines_seen), .line_err(line_err), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int ncall = 0, vs_call = 0, valid_call = 0, valid_cnt = 0;
  int short_v = -1, drop_v = -1, ovr_h = -1, ovr_v = -1;
  bit clr_close = 1'b0;
  logic [15:0] gold, base;
  logic [15:0] cap_crc, cap_fc;
  logic [10:0] cap_lines;
  logic        cap_le, cap_fe;

  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 11; i >= 0; i--) begin
      logic fb;
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one pixel clock, then sample outputs 1ns after the edge.
  task automatic cyc(input int h, input int v);
    logic hb, vb;
    logic [11:0] px;
    hb = (h >= 8) || (h == 7 && v == short_v);
    vb = (v >= 4) || (v == drop_v);
    px = (h == ovr_h && v == ovr_v) ? 12'hFFF
                                    : {v[3:0], h[3:0], h[3:0] ^ v[3:0]};
    vga.hcount = 11'(h);
    vga.vcount = 11'(v);
    vga.hblnk  = hb;
    vga.vblnk  = vb;
    vga.hsync  = (h == 9 || h == 10);
    vga.vsync  = (v == 4);
    rgb        = px;
    clr        = clr_close && v == 4 && h == 1;
    if (!hb && !vb) gold = ref_crc(gold, px);
    if (v == 4 && h == 0) vs_call = ncall;
    @(posedge clk); #1;
    if (crc_valid) begin
      valid_cnt++;
      valid_call = ncall;
      cap_crc    = crc;
      cap_fc     = frame_cnt;
      cap_lines  = lines_seen;
      cap_le     = line_err;
      cap_fe     = frame_err;
    end
    ncall++;
  endtask

  // One frame as the checker sees it: blank line 5, active 0..3, vsync line 4.
  task automatic frame(input int rst_line);
    int vl[6];
    vl = '{5, 0, 1, 2, 3, 4};
    gold = 16'hFFFF;
    valid_cnt = 0;
    for (int i = 0; i < 6; i++)
      for (int h = 0; h < 12; h++) begin
        cyc(h, vl[i]);
        if (vl[i] == rst_line && h == 3) begin
          #1 rst_n = 1'b0;
          #1;
          chk("rst_crc", crc, 0);
          chk("rst_valid", crc_valid, 0);
          chk("rst_fc", frame_cnt, 0);
          chk("rst_lines", lines_seen, 0);
          chk("rst_le", line_err, 0);
          chk("rst_fe", frame_err, 0);
        end
        if (vl[i] == rst_line && h == 6) rst_n = 1'b1;
      end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; rgb = '0;
    vga.hcount = '0; vga.vcount = '0; vga.hblnk = 1'b1;
    vga.vblnk = 1'b1; vga.hsync = 1'b0; vga.vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_crc", crc, 0);
    chk("reset_valid", crc_valid, 0);
    chk("reset_fc", frame_cnt, 0);
    chk("reset_lines", lines_seen, 0);
    chk("reset_le", line_err, 0);
    chk("reset_fe", frame_err, 0);
    rst_n = 1'b1;

    // Hand-derived: 12 zero bits into a 0xFFFF seed.
    chk("pkg_step", crc16_step12(16'hFFFF, 12'h000), 16'hFECE);
    chk("ref_step", ref_crc(16'hFFFF, 12'h000), 16'hFECE);

    frame(-1);
    chk("arm_no_valid", valid_cnt, 0);

    frame(-1);
    base = gold;
    chk("f1_valid", valid_cnt, 1);
    chk("f1_latency", valid_call - vs_call, 1);
    chk("f1_crc", cap_crc, gold);
    chk("f1_lines", cap_lines, 4);
    chk("f1_fc", cap_fc, 1);
    chk("f1_le", cap_le, 0);
    chk("f1_fe", cap_fe, 0);
    chk("f1_hold", crc, gold);

    frame(-1);
    chk("f2_valid", valid_cnt, 1);
    chk("f2_crc_stable", cap_crc, base);
    chk("f2_fc", cap_fc, 2);

    ovr_h = 2; ovr_v = 1;
    frame(-1);
    ovr_h = -1; ovr_v = -1;
    chk("pix_crc", cap_crc, gold);
    chk("pix_differs", cap_crc != base, 1);
    chk("pix_fc", cap_fc, 3);

    frame(-1);
    chk("pix_back", cap_crc, base);

    short_v = 2;
    frame(-1);
    short_v = -1;
    chk("short_le", cap_le, 1);
    chk("short_fe", cap_fe, 0);
    chk("short_lines", cap_lines, 4);
    chk("short_crc", cap_crc, gold);
    chk("short_differs", cap_crc != base, 1);

    frame(-1);
    chk("sticky_le", cap_le, 1);
    chk("sticky_crc", cap_crc, base);
    chk("sticky_fc", cap_fc, 6);

    clr_close = 1'b1;
    frame(-1);
    clr_close = 1'b0;
    chk("clr_valid", valid_cnt, 1);
    chk("clr_fc", cap_fc, 0);
    chk("clr_le", cap_le, 0);
    chk("clr_crc", cap_crc, base);

    drop_v = 1;
    frame(-1);
    drop_v = -1;
    chk("drop_lines", cap_lines, 3);
    chk("drop_fe", cap_fe, 1);
    chk("drop_le", cap_le, 0);
    chk("drop_crc", cap_crc, gold);
    chk("drop_fc", cap_fc, 1);

    frame(-1);
    chk("fe_sticky", cap_fe, 1);
    chk("fe_lines", cap_lines, 4);
    chk("fe_fc", cap_fc, 2);

    frame(2);
    chk("rst_no_valid", valid_cnt, 0);

    frame(-1);
    chk("post_rst_valid", valid_cnt, 1);
    chk("post_rst_latency", valid_call - vs_call, 1);
    chk("post_rst_crc", cap_crc, base);
    chk("post_rst_fc", cap_fc, 1);
    chk("post_rst_fe", cap_fe, 0);
    chk("post_rst_le", cap_le, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_frame_checker.md
# vga_frame_checker

Passive sink for the pixel stream that `draw` produces (`vga_if` plus `rgb`). It computes a CRC-16 signature of every complete frame's active area and checks the frame geometry against the 1024x768 active window (1328x806 total at 75 MHz). It is the on-chip and bench-side counterpart to the renderer: simulation regressions compare signatures instead of TIFF dumps, and hardware can expose the signature for self-test.

## Interface
Parameters:
- `H_ACTIVE`, 1024: active pixels per line.
- `V_ACTIVE`, 768: active lines per frame.
- `CRC_INIT`, 16'hFFFF: CRC seed loaded at each frame start.

Ports:
- `clk`  input  1: pixel clock, 75 MHz.
- `rst`  input  1: reset, asynchronous and active-low.
- `vga_in`  input  vga_if (in modport): `hcount`, `vcount`, `hblnk`, `vblnk`, `hsync`, `vsync`.
- `rgb`  input  RGB_B (12): pixel colour, aligned with `vga_in`.
- `clr`  input  1: synchronous clear of `frame_cnt` and the sticky error flags.
- `crc`  output  16: signature of the last complete frame.
- `crc_valid`  output  1: one-cycle pulse when `crc` and the status outputs update.
- `frame_cnt`  output  16: number of complete frames checked.
- `lines_seen`  output  11: active lines counted in the last frame.
- `line_err`  output  1: sticky; set when any active line has a pixel count other than `H_ACTIVE`.
- `frame_err`  output  1: sticky; set when a frame has `lines_seen != V_ACTIVE`.

## Operation
- Input stage: `vga_in` and `rgb` are registered once.
- All detection logic works on the registered copy.
- An active pixel is a registered cycle with `!hblnk && !vblnk`.
- FSM `IDLE -> CAPTURE`:
  - `IDLE`: entered on reset. Waits for a vsync rising edge (registered vsync 0 -> 1), then loads the CRC with `CRC_INIT`, clears the accumulators and moves to `CAPTURE`. No `crc_valid` is raised on this edge, so a partial first frame is discarded.
  - `CAPTURE`: each active pixel updates the CRC.
    - On each vsync rising edge the frame closes: publish the results, check them, reseed and stay in `CAPTURE`.
- CRC: CRC-16-CCITT, polynomial 0x1021, non-reflected, no final XOR. The full 12-bit pixel is shifted in per clock, MSB first ({r,g,b}, r[3] first).
- Line check:
  - `px_in_line` counts active pixels and clears when hblnk rises.
  - At a hblnk rising edge with `px_in_line != 0`: compare against `H_ACTIVE`; a mismatch sets `line_err`.
  - The same event increments `line_acc`.
- Frame close:
  - `crc <= crc_acc`, `lines_seen <= line_acc`.
  - `frame_cnt` increments, wrapping 16'hFFFF -> 0.
  - `frame_err` is set if `line_acc != V_ACTIVE`.
  - `crc_valid` pulses.
- An active pixel on the same registered cycle as the vsync rise belongs to the closing frame.
- `clr` clears `frame_cnt`, `line_err` and `frame_err`.
  - It has priority over a coinciding frame close: `crc`, `lines_seen` and `crc_valid` still update, but `frame_cnt` goes to 0 and the errors stay 0.
  - `clr` does not change the FSM state.

## Timing
- Reset values: `crc`=0, `crc_valid`=0, `frame_cnt`=0, `lines_seen`=0, `line_err`=0, `frame_err`=0, FSM=`IDLE`.
- Latency: the input vsync rises at cycle N. The registered edge is seen at N+1. The outputs update and `crc_valid`=1 during cycle N+2, for exactly one cycle.
- The outputs hold their values until the next frame close.
- Reset mid-frame:
  - All state clears immediately (asynchronous).
  - The first vsync edge after reset deassertion arms the block.
  - The first `crc_valid` appears at the second vsync edge.
- No backpressure: the block never stalls the stream.

## Structure
- The CRC polynomial constant and a `crc16_step12(crc, data)` function go in `snake_pkg`, next to `RGB_B`, so benches can build the golden model from them.
- One sub-module, `crc16_12b`, holds the registered CRC accumulator with seed/enable ports.
- Line and frame counters and the FSM stay in `vga_frame_checker`.

## Test plan
- All-black input: `vga_timing` + `draw` with `rgb` forced to 0 for two frames -> `crc` equals the package-function golden over 786432 zero pixels; `lines_seen`=768; `frame_cnt`=1; errors 0.
- Stable frames: `draw` in MENU mode -> consecutive `crc_valid` pulses carry identical `crc`; `frame_cnt` goes 1, 2, 3.
- Single-pixel change: force `rgb`=12'hFFF at (20,20) for one frame -> only that frame's `crc` differs, and the next frame returns to the baseline value.
- Short line: force hblnk high 1 cycle early on line 100 -> `line_err`=1 and stays sticky; `frame_err`=0; the next frame's `crc` differs.
- Mid-frame reset: pull `rst` low at line 400 -> all outputs 0 at once; no `crc_valid` at the first vsync after release; a valid pulse 2 cycles after the second vsync rise.
- `clr` on the `crc_valid` cycle with `line_err`=1 -> `frame_cnt`=0 and `line_err`=0 next cycle, while `crc` still updates.
